// File: rtl/mux_rr_scan_ctrl.sv
// Round-robin scheduler sharing an 8-to-1 single-bit mux among 8 channels:
// fixed-length grant slots, bit-reversed mux select, one settled sample per slot.
`timescale 1ns/1ps
module mux_rr_scan_ctrl #(
  parameter int unsigned SLOT_LEN = 4,
  parameter int unsigned SETTLE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       mux_out,
  output logic [2:0] control,
  output logic [7:0] grant,
  output logic [2:0] ch_idx,
  output logic       busy,
  output logic       sample_valid,
  output logic       sample_bit,
  output logic [2:0] sample_ch
);

  if (SLOT_LEN < 1 || SLOT_LEN > 255 || SETTLE >= SLOT_LEN) begin : g_param_err
    $error("mux_rr_scan_ctrl: need 1 <= SLOT_LEN <= 255 and SETTLE < SLOT_LEN");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SLOT = 1'b1;
  localparam logic [7:0] LAST_CNT   = 8'(SLOT_LEN - 1);
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  logic [0:0] state;
  logic [7:0] cnt;
  logic [2:0] last;
  logic [3:0] pick;
  logic       slot_end;
  logic       arb;

  // {found, index}: first requester after p, circularly; p itself is checked last.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] c;
    res = 4'b0;
    for (int k = 8; k >= 1; k--) begin
      c = p + 3'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  // The mux decodes its select LSB-first, so the channel index is bit-reversed.
  function automatic logic [2:0] enc_sel(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

  assign pick     = rr_pick(req, last);
  assign slot_end = (state == SLOT) && (cnt == LAST_CNT);
  assign arb      = ((state == IDLE) || slot_end) && en && pick[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      last         <= 3'd7;
      control      <= 3'b000;
      grant        <= 8'd0;
      ch_idx       <= 3'd0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_bit   <= 1'b0;
      sample_ch    <= 3'd0;
    end else begin
      sample_valid <= 1'b0;
      if (state == SLOT && cnt == SETTLE_CNT) begin
        sample_valid <= 1'b1;
        sample_bit   <= mux_out;
        sample_ch    <= ch_idx;
      end
      if (state == SLOT) cnt <= cnt + 8'd1;
      // Slot end and a new grant may coincide: arbitration wins, no idle gap.
      if (arb) begin
        state   <= SLOT;
        grant   <= 8'b1 << pick[2:0];
        ch_idx  <= pick[2:0];
        control <= enc_sel(pick[2:0]);
        busy    <= 1'b1;
        cnt     <= 8'd0;
        last    <= pick[2:0];
      end else if (slot_end) begin
        state <= IDLE;
        grant <= 8'd0;
        busy  <= 1'b0;
      end
    end
  end

endmodule
